uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: 16x-oversampling UART receiver with programmable baud divisor,
// optional parity, 1 or 2 stop bits, sticky error flags and a first-word-fall-
// through receive FIFO.
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          PCLK,
    input  logic                          PRESETN,
    input  logic [12:0]                   BAUD_VAL,
    input  logic                          RX,
    input  logic                          RD_EN,
    input  logic                          CLR_ERR,
    output logic [DATA_WIDTH-1:0]         RDATA,
    output logic                          RXRDY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          PARITY_ERR,
    output logic                          FRAMING_ERR,
    output logic                          OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [3:0]  LP_LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]  LP_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0] LP_DEPTH     = (AW + 1)'(FIFO_DEPTH);

    // Synchroniser and edge detector
    logic [1:0]  r_sync;
    logic        r_rx_prev;
    logic        w_rx;

    // Baud generator
    logic [12:0] r_baud_cnt;
    logic [12:0] r_baud_lim;
    logic        w_tick;

    // Receive state machine
    logic [2:0]            r_state;
    logic [3:0]            r_os_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bad;
    logic                  r_stop_bad;
    logic                  r_brk;
    logic                  r_push;
    logic                  r_push_par;
    logic                  r_fe_set;
    logic                  w_par_exp;
    logic                  w_stop_bad_now;

    // FIFO
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_ovf;

    // Error flags
    logic r_perr;
    logic r_ferr;
    logic r_ovf;

    assign w_rx           = r_sync[1];
    assign w_tick         = (r_baud_cnt == r_baud_lim);
    assign w_par_exp      = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_stop_bad_now = r_stop_bad | ~w_rx;

    // Bring RX into the PCLK domain and keep its previous value for edge detection
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], RX};
            r_rx_prev <= r_sync[1];
        end
    end

    // Free-running oversample tick; a new divisor is only picked up on reload
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_baud_cnt <= '0;
            r_baud_lim <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
            r_baud_lim <= BAUD_VAL;
        end else begin
            r_baud_cnt <= r_baud_cnt + 13'd1;
        end
    end

    // Frame reception: start validation, LSB-first data, optional parity, stop bits
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state    <= S_IDLE;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_brk      <= 1'b0;
            r_push     <= 1'b0;
            r_push_par <= 1'b0;
            r_fe_set   <= 1'b0;
        end else begin
            r_push   <= 1'b0;
            r_fe_set <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // After a framing error the line must go high again (end of
                    // break) before a new start edge is accepted.
                    if (r_brk) begin
                        if (w_rx) r_brk <= 1'b0;
                    end else if (r_rx_prev && !w_rx) begin
                        r_state    <= S_START;
                        r_os_cnt   <= '0;
                        r_par_bad  <= 1'b0;
                        r_stop_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_os_cnt == 4'd7) begin
                            r_os_cnt <= '0;
                            if (!w_rx) begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == 4'd15) begin
                            r_os_cnt <= '0;
                            r_shift  <= {w_rx, r_shift[DATA_WIDTH-1:1]};
                            if (r_bit_cnt == LP_LAST_DATA) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_os_cnt == 4'd15) begin
                            r_os_cnt  <= '0;
                            r_par_bad <= (w_rx != w_par_exp);
                            r_bit_cnt <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_os_cnt == 4'd15) begin
                            r_os_cnt <= '0;
                            if (r_bit_cnt == LP_LAST_STOP) begin
                                r_state <= S_IDLE;
                                if (w_stop_bad_now) begin
                                    r_fe_set <= 1'b1;
                                    r_brk    <= 1'b1;
                                end else begin
                                    r_push     <= 1'b1;
                                    r_push_par <= r_par_bad;
                                end
                            end else begin
                                r_bit_cnt  <= r_bit_cnt + 4'd1;
                                r_stop_bad <= w_stop_bad_now;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop frees a slot for a simultaneous push even when full; pops while
    // empty are ignored.
    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_rd    = RD_EN & ~w_empty;
    assign w_wr    = r_push & (~w_full | w_rd);
    assign w_ovf   = r_push & w_full & ~w_rd;

    // FIFO storage; the shift register is stable during the push cycle
    always_ff @(posedge PCLK) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_perr <= (r_push & r_push_par) | (r_perr & ~CLR_ERR);
            r_ferr <= r_fe_set | (r_ferr & ~CLR_ERR);
            r_ovf  <= w_ovf | (r_ovf & ~CLR_ERR);
        end
    end

    assign RDATA       = w_empty ? '0 : r_mem[r_rptr];
    assign RXRDY       = ~w_empty;
    assign FIFO_COUNT  = r_count;
    assign PARITY_ERR  = r_perr;
    assign FRAMING_ERR = r_ferr;
    assign OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param. Two instances:
// u_dut0 = 8N1 with a 4-entry FIFO, u_dut1 = 8 data, even parity, 2 stop bits.
module tb_uart_rx_param;

    logic        clk;
    logic        rst_n;
    logic [12:0] baud;
    logic        rx0, rx1, rd0, rd1, clr0, clr1;
    logic [7:0]  rdata0, rdata1;
    logic        rdy0, rdy1, perr0, perr1, ferr0, ferr1, ovf0, ovf1;
    logic [2:0]  cnt0;
    logic [4:0]  cnt1;

    int n_cmp;
    int n_err;

    uart_rx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .PCLK(clk), .PRESETN(rst_n), .BAUD_VAL(baud), .RX(rx0), .RD_EN(rd0), .CLR_ERR(clr0),
        .RDATA(rdata0), .RXRDY(rdy0), .FIFO_COUNT(cnt0),
        .PARITY_ERR(perr0), .FRAMING_ERR(ferr0), .OVERFLOW(ovf0));

    uart_rx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .PCLK(clk), .PRESETN(rst_n), .BAUD_VAL(baud), .RX(rx1), .RD_EN(rd1), .CLR_ERR(clr1),
        .RDATA(rdata1), .RXRDY(rdy1), .FIFO_COUNT(cnt1),
        .PARITY_ERR(perr1), .FRAMING_ERR(ferr1), .OVERFLOW(ovf1));

    always #5 clk = ~clk;

    // 8N1 frame, LSB first: start, data, stop
    function automatic logic [15:0] f0(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    // 8 data + parity + 2 stops
    function automatic logic [15:0] f1(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        return {4'b0, s2, s1, par, d, 1'b0};
    endfunction

    // Each bit lasts 16 ticks; BAUD_VAL stays 0 so one tick per clock
    task automatic send(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i];
            else            rx1 = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic rd_pulse(input int which);
        @(negedge clk);
        if (which == 0) rd0 = 1'b1; else rd1 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic clr_pulse(input int which);
        @(negedge clk);
        if (which == 0) clr0 = 1'b1; else clr1 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        clr1 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (rdy0 !== 1'b0)  begin n_err++; $display("FAIL rst_rxrdy0: got %b want 0", rdy0); end
        n_cmp++; if (cnt0 !== 3'd0)  begin n_err++; $display("FAIL rst_count0: got %0d want 0", cnt0); end
        n_cmp++; if (rdata0 !== 8'h00) begin n_err++; $display("FAIL rst_rdata0: got %h want 00", rdata0); end
        n_cmp++; if ({perr0, ferr0, ovf0} !== 3'b000) begin n_err++; $display("FAIL rst_flags0: got %b want 000", {perr0, ferr0, ovf0}); end
        n_cmp++; if ({rdy1, perr1, ferr1, ovf1} !== 4'b0000) begin n_err++; $display("FAIL rst_misc1: got %b want 0000", {rdy1, perr1, ferr1, ovf1}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if ({rdy0, rdy1} !== 2'b00) begin n_err++; $display("FAIL post_rst_rxrdy: got %b want 00", {rdy0, rdy1}); end
        n_cmp++; if (cnt1 !== 5'd0) begin n_err++; $display("FAIL post_rst_count1: got %0d want 0", cnt1); end
    endtask

    task automatic test_basic;
        @(negedge clk);
        fork
            send(0, f0(8'hA5, 1'b1), 10);
            begin
                // stop mid-sample lands in the 154th cycle after the RX fall
                repeat (155) @(posedge clk);
                #1;
                n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL basic_early: rxrdy got %b want 0", rdy0); end
                @(posedge clk);
                #1;
                n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL basic_rxrdy: got %b want 1", rdy0); end
                n_cmp++; if (rdata0 !== 8'hA5) begin n_err++; $display("FAIL basic_rdata: got %h want a5", rdata0); end
                n_cmp++; if (cnt0 !== 3'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", cnt0); end
            end
        join
        rd_pulse(0);
        n_cmp++; if ({rdy0, cnt0} !== 4'b0000) begin n_err++; $display("FAIL basic_pop: rxrdy,count got %b want 0000", {rdy0, cnt0}); end
        n_cmp++; if (rdata0 !== 8'h00) begin n_err++; $display("FAIL basic_empty_rdata: got %h want 00", rdata0); end
        rd_pulse(0);
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL empty_read_count: got %0d want 0", cnt0); end
        n_cmp++; if ({perr0, ferr0, ovf0} !== 3'b000) begin n_err++; $display("FAIL empty_read_flags: got %b want 000", {perr0, ferr0, ovf0}); end
    endtask

    task automatic test_parity;
        // 0x03 has two ones: even parity bit is 0, so 1 is wrong
        send(1, f1(8'h03, 1'b1, 1'b1, 1'b1), 12);
        n_cmp++; if (cnt1 !== 5'd1) begin n_err++; $display("FAIL par_count: got %0d want 1", cnt1); end
        n_cmp++; if (rdata1 !== 8'h03) begin n_err++; $display("FAIL par_rdata: got %h want 03", rdata1); end
        n_cmp++; if (perr1 !== 1'b1) begin n_err++; $display("FAIL par_flag: got %b want 1", perr1); end
        n_cmp++; if (ferr1 !== 1'b0) begin n_err++; $display("FAIL par_no_ferr: got %b want 0", ferr1); end
        clr_pulse(1);
        n_cmp++; if (perr1 !== 1'b0) begin n_err++; $display("FAIL par_clear: got %b want 0", perr1); end
        // 0x07 has three ones: even parity bit is 1, correct
        send(1, f1(8'h07, 1'b1, 1'b1, 1'b1), 12);
        n_cmp++; if (perr1 !== 1'b0) begin n_err++; $display("FAIL par_good: got %b want 0", perr1); end
        n_cmp++; if (cnt1 !== 5'd2) begin n_err++; $display("FAIL par_count2: got %0d want 2", cnt1); end
        n_cmp++; if (rdata1 !== 8'h03) begin n_err++; $display("FAIL par_head1: got %h want 03", rdata1); end
        rd_pulse(1);
        n_cmp++; if (rdata1 !== 8'h07) begin n_err++; $display("FAIL par_head2: got %h want 07", rdata1); end
        rd_pulse(1);
        n_cmp++; if (cnt1 !== 5'd0) begin n_err++; $display("FAIL par_drain: got %0d want 0", cnt1); end
    endtask

    task automatic test_framing;
        send(0, f0(8'h5A, 1'b0), 10);
        repeat (40 * 16) @(negedge clk);
        n_cmp++; if (ferr0 !== 1'b1) begin n_err++; $display("FAIL fe_flag: got %b want 1", ferr0); end
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL fe_count: got %0d want 0", cnt0); end
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        send(0, f0(8'h3C, 1'b1), 10);
        n_cmp++; if (cnt0 !== 3'd1) begin n_err++; $display("FAIL fe_next_count: got %0d want 1", cnt0); end
        n_cmp++; if (rdata0 !== 8'h3C) begin n_err++; $display("FAIL fe_next_rdata: got %h want 3c", rdata0); end
        n_cmp++; if (ferr0 !== 1'b1) begin n_err++; $display("FAIL fe_sticky: got %b want 1", ferr0); end
        clr_pulse(0);
        n_cmp++; if (ferr0 !== 1'b0) begin n_err++; $display("FAIL fe_clear: got %b want 0", ferr0); end
        rd_pulse(0);
    endtask

    task automatic test_overflow;
        logic [7:0] want;
        for (int i = 1; i <= 5; i++) send(0, f0(8'(i * 17), 1'b1), 10);
        n_cmp++; if (cnt0 !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", cnt0); end
        n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf0); end
        for (int i = 1; i <= 4; i++) begin
            want = 8'(i * 17);
            n_cmp++; if (rdata0 !== want) begin n_err++; $display("FAIL ovf_order%0d: got %h want %h", i, rdata0, want); end
            rd_pulse(0);
        end
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL ovf_drain: got %0d want 0", cnt0); end
        clr_pulse(0);
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
    endtask

    task automatic test_full_pop;
        logic [7:0] want;
        for (int i = 1; i <= 4; i++) send(0, f0(8'hA0 + 8'(i), 1'b1), 10);
        n_cmp++; if (cnt0 !== 3'd4) begin n_err++; $display("FAIL fp_fill: got %0d want 4", cnt0); end
        @(negedge clk);
        fork
            send(0, f0(8'hA5, 1'b1), 10);
            begin
                // push happens in the cycle after the 155th edge
                repeat (155) @(posedge clk);
                @(negedge clk);
                rd0 = 1'b1;
                @(negedge clk);
                rd0 = 1'b0;
            end
        join
        n_cmp++; if (cnt0 !== 3'd4) begin n_err++; $display("FAIL fp_count: got %0d want 4", cnt0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL fp_no_ovf: got %b want 0", ovf0); end
        for (int i = 2; i <= 5; i++) begin
            want = 8'hA0 + 8'(i);
            n_cmp++; if (rdata0 !== want) begin n_err++; $display("FAIL fp_order%0d: got %h want %h", i, rdata0, want); end
            rd_pulse(0);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", cnt0); end
        n_cmp++; if ({perr0, ferr0, ovf0} !== 3'b000) begin n_err++; $display("FAIL glitch_flags: got %b want 000", {perr0, ferr0, ovf0}); end
        send(0, f0(8'h96, 1'b1), 10);
        n_cmp++; if (rdata0 !== 8'h96) begin n_err++; $display("FAIL glitch_after: got %h want 96", rdata0); end
    endtask

    task automatic test_reset_mid;
        // leave a framing error on dut1 and a stored word on dut0
        send(1, f1(8'hFF, 1'b0, 1'b0, 1'b1), 12);
        n_cmp++; if (ferr1 !== 1'b1) begin n_err++; $display("FAIL rm_pre_ferr1: got %b want 1", ferr1); end
        @(negedge clk);
        rx0 = 1'b0;
        repeat (64) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rdy0, cnt0} !== 4'b0000) begin n_err++; $display("FAIL rm_fifo0: got %b want 0000", {rdy0, cnt0}); end
        n_cmp++; if (rdata0 !== 8'h00) begin n_err++; $display("FAIL rm_rdata0: got %h want 00", rdata0); end
        n_cmp++; if (ferr1 !== 1'b0) begin n_err++; $display("FAIL rm_ferr1: got %b want 0", ferr1); end
        @(negedge clk);
        rx0 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL rm_no_push: got %0d want 0", cnt0); end
        n_cmp++; if ({perr0, ferr0, ovf0} !== 3'b000) begin n_err++; $display("FAIL rm_no_flag: got %b want 000", {perr0, ferr0, ovf0}); end
        send(0, f0(8'h5C, 1'b1), 10);
        n_cmp++; if (rdata0 !== 8'h5C) begin n_err++; $display("FAIL rm_resume: got %h want 5c", rdata0); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        baud  = 13'd0;
        rx0   = 1'b1;
        rx1   = 1'b1;
        rd0   = 1'b0;
        rd1   = 1'b0;
        clr0  = 1'b0;
        clr1  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_parity;
        test_framing;
        test_overflow;
        test_full_pop;
        test_glitch;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
